// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO write-side packer.
package async_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } wr_state_e;

    localparam int PACK_BUF_DEPTH = 2;

    function automatic int ratio(input int width, input int in_width);
        return width / in_width;
    endfunction

endpackage

// File: rtl/packer_word_buf.sv
// Two-entry word buffer between the beat packer and the FIFO write issuer.
module packer_word_buf
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_wr,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [PACK_BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk_wr) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'(PACK_BUF_DEPTH));
    assign empty = (count == 2'd0);

endmodule

// File: rtl/async_fifo_wr_packer.sv
// Packs narrow producer beats into FIFO words and paces writes on the FIFO full flag.
// Optional WR_PACKER_STATS_EN adds saturating write/stall counters.
module async_fifo_wr_packer
    import async_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int IN_WIDTH = 2
) (
    input  logic                clk_wr,
    input  logic                rst_n,
    input  logic                in_vld,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_last,
    output logic                in_rdy,
    input  logic                full,
    output logic                wr_en,
    output logic                data_in_vld,
    output logic [WIDTH-1:0]    data_in,
    output logic                busy
`ifdef WR_PACKER_STATS_EN
    ,
    output logic [15:0]         wr_cnt,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int RATIO = ratio(WIDTH, IN_WIDTH);
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [CNT_W-1:0] beat_cnt;
    logic [WIDTH-1:0] pack_q;
    logic [WIDTH-1:0] word;
    logic             rdy_q;
    logic             accept;
    logic             complete;
    wr_state_e        state;

    logic [WIDTH-1:0] buf_head;
    logic [1:0]       buf_count;
    logic             buf_full;
    logic             buf_empty;

    assign in_rdy   = rdy_q && !buf_full;
    assign accept   = in_vld && in_rdy;
    assign complete = accept && ((beat_cnt == CNT_W'(RATIO - 1)) || in_last);

    // Slices below the counter come from earlier beats; above it are zero-padded.
    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (i < int'(beat_cnt))
                word[i*IN_WIDTH +: IN_WIDTH] = pack_q[i*IN_WIDTH +: IN_WIDTH];
            else if (i == int'(beat_cnt))
                word[i*IN_WIDTH +: IN_WIDTH] = in_data;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) beat_cnt <= complete ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_wr) begin
        if (accept) pack_q <= complete ? '0 : word;
    end

    packer_word_buf #(.WIDTH(WIDTH)) u_buf (
        .clk_wr    (clk_wr),
        .rst_n     (rst_n),
        .push      (complete),
        .push_data (word),
        .pop       (wr_en),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // GUARD absorbs the one-cycle lag of the registered full flag after a write.
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (!buf_empty) state <= ISSUE;
                ISSUE:   if (!full) state <= GUARD;
                GUARD:   state <= WAIT;
                WAIT:    if (!full) state <= buf_empty ? IDLE : ISSUE;
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_en       = (state == ISSUE) && !full;
    assign data_in_vld = wr_en;
    assign data_in     = buf_empty ? '0 : buf_head;
    assign busy        = (beat_cnt != '0) || (buf_count != 2'd0) || (state != IDLE);

`ifdef WR_PACKER_STATS_EN
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (wr_en && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
            if ((state == ISSUE) && full && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_wr_packer.sv
// Directed bench for async_fifo_wr_packer (WIDTH=8, IN_WIDTH=2).
module tb_async_fifo_wr_packer;

    logic       clk_wr  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       in_vld  = 1'b0;
    logic [1:0] in_data = 2'd0;
    logic       in_last = 1'b0;
    logic       full    = 1'b0;
    logic       in_rdy;
    logic       wr_en;
    logic       data_in_vld;
    logic [7:0] data_in;
    logic       busy;
`ifdef WR_PACKER_STATS_EN
    logic [15:0] wr_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int full_writes = 0;
    logic [7:0] wq[$];
    int wcyc[$];

    async_fifo_wr_packer #(.WIDTH(8), .IN_WIDTH(2)) dut (
        .clk_wr      (clk_wr),
        .rst_n       (rst_n),
        .in_vld      (in_vld),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_rdy      (in_rdy),
        .full        (full),
        .wr_en       (wr_en),
        .data_in_vld (data_in_vld),
        .data_in     (data_in),
        .busy        (busy)
`ifdef WR_PACKER_STATS_EN
        ,
        .wr_cnt      (wr_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk_wr = ~clk_wr;

    always @(posedge clk_wr) cyc <= cyc + 1;

    always @(negedge clk_wr) begin
        if (rst_n && wr_en) begin
            wq.push_back(data_in);
            wcyc.push_back(cyc);
            if (full) full_writes++;
            if (data_in_vld !== 1'b1) begin
                errors++;
                $display("FAIL data_in_vld_tracks_wr_en got=%b exp=1", data_in_vld);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_wr);
            #1;
        end
    endtask

    task automatic clear_log();
        wq.delete();
        wcyc.delete();
        full_writes = 0;
    endtask

    // Called at posedge+1; returns with the beat accepted and inputs idle at the next posedge+1.
    task automatic send_beat(input logic [1:0] d, input logic last, output int acc);
        int n;
        acc = -1;
        in_vld  = 1'b1;
        in_data = d;
        in_last = last;
        n = 0;
        @(negedge clk_wr);
        while (!in_rdy && n < 300) begin
            @(negedge clk_wr);
            n++;
        end
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept_timeout in_rdy=%b exp=1", in_rdy);
        end else begin
            acc = cyc;
        end
        @(posedge clk_wr);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, output int acc);
        for (int i = 0; i < 4; i++) send_beat(w[i*2 +: 2], 1'b0, acc);
    endtask

    task automatic test_reset();
        tick(3);
        @(negedge clk_wr);
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++; if (data_in_vld !== 1'b0) begin errors++; $display("FAIL reset_data_in_vld got=%b exp=0", data_in_vld); end
        checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in got=%h exp=00", data_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk_wr);
        #1;
        rst_n = 1'b1;
        tick(1);
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_in_rdy got=%b exp=1", in_rdy); end
    endtask

    task automatic test_single_word();
        int acc;
        clear_log();
        full = 1'b0;
        send_beat(2'd1, 1'b0, acc);
        send_beat(2'd2, 1'b0, acc);
        send_beat(2'd3, 1'b0, acc);
        send_beat(2'd0, 1'b0, acc);
        tick(8);
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL single_write_count got=%0d exp=1", wq.size()); end
        checks++; if (wq.size() < 1 || wq[0] !== 8'h39) begin errors++; $display("FAIL single_data got=%h exp=39", (wq.size() > 0) ? wq[0] : 8'hxx); end
        checks++; if (wcyc.size() < 1 || wcyc[0] != acc + 2) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", (wcyc.size() > 0) ? wcyc[0] : -1, acc + 2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_last_flush();
        int acc;
        clear_log();
        send_beat(2'd3, 1'b0, acc);
        send_beat(2'd1, 1'b0, acc);
        send_beat(2'd2, 1'b1, acc);
        tick(8);
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL flush_write_count got=%0d exp=1", wq.size()); end
        checks++; if (wq.size() < 1 || wq[0] !== 8'h27) begin errors++; $display("FAIL flush_data got=%h exp=27", (wq.size() > 0) ? wq[0] : 8'hxx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    endtask

    task automatic test_last_idle();
        clear_log();
        in_last = 1'b1;
        tick(4);
        in_last = 1'b0;
        tick(4);
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL idle_last_writes got=%0d exp=0", wq.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_last_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full_backpressure();
        int a1;
        int a2;
        int a3;
        clear_log();
        full = 1'b1;
        send_word(8'hA5, a1);
        send_word(8'h3C, a2);
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy_low got=%b exp=0", in_rdy); end
        fork
            send_word(8'hE1, a3);
            begin
                tick(12);
                checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy_held got=%b exp=0", in_rdy); end
                checks++; if (wq.size() != 0) begin errors++; $display("FAIL bp_no_write got=%0d exp=0", wq.size()); end
                full = 1'b0;
            end
        join
        tick(20);
        checks++; if (wq.size() != 3) begin errors++; $display("FAIL bp_write_count got=%0d exp=3", wq.size()); end
        if (wq.size() == 3) begin
            checks++; if (wq[0] !== 8'hA5) begin errors++; $display("FAIL bp_order0 got=%h exp=a5", wq[0]); end
            checks++; if (wq[1] !== 8'h3C) begin errors++; $display("FAIL bp_order1 got=%h exp=3c", wq[1]); end
            checks++; if (wq[2] !== 8'hE1) begin errors++; $display("FAIL bp_order2 got=%h exp=e1", wq[2]); end
            checks++; if (wcyc[1] - wcyc[0] < 3) begin errors++; $display("FAIL bp_gap01 got=%0d exp>=3", wcyc[1] - wcyc[0]); end
            checks++; if (wcyc[2] - wcyc[1] < 3) begin errors++; $display("FAIL bp_gap12 got=%0d exp>=3", wcyc[2] - wcyc[1]); end
        end
        checks++; if (full_writes != 0) begin errors++; $display("FAIL bp_write_while_full got=%0d exp=0", full_writes); end
    endtask

    task automatic test_full_pacing();
        int a;
        int k;
        logic [7:0] exp_w [4];
        exp_w = '{8'h12, 8'h34, 8'h56, 8'h78};
        clear_log();
        full = 1'b0;
        fork
            for (int i = 0; i < 4; i++) send_word(exp_w[i], a);
            begin
                k = 0;
                while (k < 150 && !(wq.size() == 4 && full == 1'b0)) begin
                    @(negedge clk_wr);
                    if (wr_en) begin
                        @(posedge clk_wr);
                        #1 full = 1'b1;
                        repeat (5) @(posedge clk_wr);
                        #1 full = 1'b0;
                    end
                    k++;
                end
            end
        join
        tick(4);
        checks++; if (wq.size() != 4) begin errors++; $display("FAIL pace_write_count got=%0d exp=4", wq.size()); end
        checks++; if (full_writes != 0) begin errors++; $display("FAIL pace_write_while_full got=%0d exp=0", full_writes); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pace_busy_end got=%b exp=0", busy); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            checks++; if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL pace_data%0d got=%h exp=%h", i, wq[i], exp_w[i]); end
        end
    endtask

    task automatic test_reset_midop();
        int a;
        clear_log();
        full = 1'b1;
        send_word(8'h99, a);
        send_beat(2'd1, 1'b0, a);
        send_beat(2'd2, 1'b0, a);
        tick(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL midop_wr_en got=%b exp=0", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midop_busy got=%b exp=0", busy); end
        checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL midop_data_in got=%h exp=00", data_in); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL midop_in_rdy got=%b exp=0", in_rdy); end
        full = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL midop_no_stale_write got=%0d exp=0", wq.size()); end
        for (int i = 0; i < 4; i++) send_beat(2'd1, 1'b0, a);
        tick(8);
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL midop_write_count got=%0d exp=1", wq.size()); end
        checks++; if (wq.size() < 1 || wq[0] !== 8'h55) begin errors++; $display("FAIL midop_data got=%h exp=55", (wq.size() > 0) ? wq[0] : 8'hxx); end
    endtask

`ifdef WR_PACKER_STATS_EN
    task automatic test_stats();
        int a;
        rst_n = 1'b0;
        full = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL stats_wr_cnt_reset got=%0d exp=0", wr_cnt); end
        clear_log();
        full = 1'b1;
        send_word(8'h0F, a);
        while (cyc < a + 9) tick(1);
        full = 1'b0;
        send_word(8'hF0, a);
        send_word(8'h5A, a);
        tick(20);
        checks++; if (wr_cnt !== 16'd3) begin errors++; $display("FAIL stats_wr_cnt got=%0d exp=3", wr_cnt); end
        checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL stats_stall_cnt got=%0d exp=7", stall_cnt); end
        checks++; if (wq.size() != 3) begin errors++; $display("FAIL stats_write_count got=%0d exp=3", wq.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_last_flush();
        test_last_idle();
        test_full_backpressure();
        test_full_pacing();
        test_reset_midop();
`ifdef WR_PACKER_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
